// File: rtl/count_display_pkg.sv
// Shared types and constants for the two-digit count display multiplexer.
package count_display_pkg;

    typedef enum logic {
        SHOW_UP   = 1'b0,
        SHOW_DOWN = 1'b1
    } scan_state_t;

    localparam int              SEG_W     = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0;
    localparam logic [1:0]       DIG_NONE  = 2'b00;
    localparam logic [1:0]       DIG_UP    = 2'b01;
    localparam logic [1:0]       DIG_DOWN  = 2'b10;

endpackage

// File: rtl/count_display_mux_if.sv
// Bundle of count inputs from the counter stage and display outputs toward the pins.
interface count_display_mux_if #(
    parameter int WIDTH = 4
);
    import count_display_pkg::*;

    logic             Enable;
    logic             Swap;
    logic [WIDTH-1:0] UpCount;
    logic [WIDTH-1:0] DownCount;
    logic [SEG_W-1:0] Segments;
    logic [1:0]       DigitSel;
    logic             Match;

    modport master (
        output Enable, Swap, UpCount, DownCount,
        input  Segments, DigitSel, Match
    );

    modport slave (
        input  Enable, Swap, UpCount, DownCount,
        output Segments, DigitSel, Match
    );

endinterface

// File: rtl/count_display_mux_hex_to_seg.sv
// Hex digit to 7-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
module hex_to_seg
    import count_display_pkg::*;
(
    input  logic [3:0]       hex,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            4'hF: seg = 7'b1110001;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_display_mux.sv
// Captures up/down counts and scans them onto a 2-digit common-bus 7-segment display.
// Build option: COUNT_DISPLAY_BLANK_EN blanks a digit whose captured value is zero.
module count_display_mux
    import count_display_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic                Clock,
    input  logic                ResetN,
    count_display_mux_if.slave  bus
);

    localparam int              PC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PC_W-1:0] PRE_MAX = PC_W'(PRESCALE - 1);

    logic [WIDTH-1:0] up_q, up_d;
    logic [WIDTH-1:0] down_q, down_d;
    logic [PC_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic             swap_q, swap_d;
    scan_state_t      state_q, state_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [1:0]       dig_q, dig_d;
    logic             match_q, match_d;

    logic             tick;
    logic             swap_evt;
    logic [WIDTH-1:0] sel_val;
    logic [SEG_W-1:0] seg_dec;

    hex_to_seg u_hex_to_seg (
        .hex (sel_val),
        .seg (seg_dec)
    );

    always_comb begin
        up_d   = up_q;
        down_d = down_q;
        if (bus.Enable) begin
            up_d   = bus.UpCount;
            down_d = bus.DownCount;
        end
    end

    // A direction change restarts the scan on digit 0 and outranks a coincident tick.
    always_comb begin
        tick      = (pre_cnt_q == PRE_MAX);
        swap_evt  = (bus.Swap != swap_q);
        swap_d    = bus.Swap;
        pre_cnt_d = tick ? '0 : pre_cnt_q + PC_W'(1);
        state_d   = state_q;
        if (swap_evt) begin
            pre_cnt_d = '0;
            state_d   = SHOW_UP;
        end else if (tick) begin
            state_d = (state_q == SHOW_UP) ? SHOW_DOWN : SHOW_UP;
        end
    end

    always_comb begin
        sel_val = (state_q == SHOW_UP) ? up_q : down_q;
        dig_d   = (state_q == SHOW_UP) ? DIG_UP : DIG_DOWN;
`ifdef COUNT_DISPLAY_BLANK_EN
        seg_d   = (sel_val == '0) ? SEG_BLANK : seg_dec;
`else
        seg_d   = seg_dec;
`endif
        match_d = (up_q == down_q);
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            up_q      <= '0;
            down_q    <= '0;
            pre_cnt_q <= '0;
            swap_q    <= 1'b0;
            state_q   <= SHOW_UP;
            seg_q     <= SEG_BLANK;
            dig_q     <= DIG_NONE;
            match_q   <= 1'b0;
        end else begin
            up_q      <= up_d;
            down_q    <= down_d;
            pre_cnt_q <= pre_cnt_d;
            swap_q    <= swap_d;
            state_q   <= state_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
            match_q   <= match_d;
        end
    end

    assign bus.Segments = seg_q;
    assign bus.DigitSel = dig_q;
    assign bus.Match    = match_q;

endmodule

// File: tb/tb_count_display_mux.sv
// Directed bench for count_display_mux with PRESCALE=4; edge numbers count from reset release.
module tb_count_display_mux;
    import count_display_pkg::*;

    localparam logic [6:0] SEG0 = 7'b0111111;
    localparam logic [6:0] SEG3 = 7'b1001111;
    localparam logic [6:0] SEG4 = 7'b1100110;
    localparam logic [6:0] SEG5 = 7'b1101101;
    localparam logic [6:0] SEG7 = 7'b0000111;
    localparam logic [6:0] SEG8 = 7'b1111111;
    localparam logic [6:0] SEGC = 7'b0111001;

    logic Clock;
    logic ResetN;
    int   nvec;
    int   nerr;
    int   e;
    logic [1:0] exp_dig;
    logic [6:0] exp_seg;

    count_display_mux_if #(.WIDTH(4)) bus ();

    count_display_mux #(.WIDTH(4), .PRESCALE(4)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        e++;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] dig, input logic [6:0] seg);
        chk({tag, ".dig"}, 8'(bus.DigitSel), 8'(dig));
        chk({tag, ".seg"}, 8'(bus.Segments), 8'(seg));
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        e    = 0;

        // reset with arbitrary inputs
        ResetN        = 1'b0;
        bus.Enable    = 1'b1;
        bus.Swap      = 1'($urandom_range(0, 1));
        bus.UpCount   = 4'($urandom_range(0, 15));
        bus.DownCount = 4'($urandom_range(0, 15));
        repeat (3) step();
        chk_out("reset", DIG_NONE, SEG_BLANK);
        chk("reset.match", 8'(bus.Match), 8'd0);

        bus.Swap      = 1'b0;
        bus.UpCount   = 4'h3;
        bus.DownCount = 4'hC;
        ResetN        = 1'b1;
        e             = 0;
        step();
        step();
        chk_out("cap.e2", DIG_UP, SEG3);
        chk("cap.e2.match", 8'(bus.Match), 8'd0);
        repeat (4) step();
        chk_out("cap.e6", DIG_DOWN, SEGC);

        // hold for 3 full scan cycles
        bus.Enable  = 1'b0;
        bus.UpCount = 4'h8;
        for (int k = 7; k <= 30; k++) begin
            step();
            exp_dig = ((((e - 1) / 4) % 2) == 0) ? DIG_UP : DIG_DOWN;
            exp_seg = (exp_dig == DIG_UP) ? SEG3 : SEGC;
            chk_out("hold", exp_dig, exp_seg);
        end
        bus.Enable = 1'b1;
        repeat (3) step();
        chk_out("recap.e33", DIG_UP, SEG8);

        // match lags capture by one edge
        bus.UpCount   = 4'h5;
        bus.DownCount = 4'h5;
        step();
        chk("match.e34", 8'(bus.Match), 8'd0);
        step();
        chk("match.e35", 8'(bus.Match), 8'd1);
        bus.DownCount = 4'h4;
        step();
        chk("match.e36", 8'(bus.Match), 8'd1);
        step();
        chk("match.e37", 8'(bus.Match), 8'd0);

        // swap while showing digit 1 with PreCnt=2
        step();
        bus.Swap = 1'b1;
        step();
        chk("swap.e39.dig", 8'(bus.DigitSel), 8'(DIG_DOWN));
        step();
        chk_out("swap.e40", DIG_UP, SEG5);
        repeat (3) step();
        chk("swap.e43.dig", 8'(bus.DigitSel), 8'(DIG_UP));
        step();
        chk_out("swap.e44", DIG_DOWN, SEG4);

        // swap coincident with a tick while showing digit 0
        repeat (6) step();
        bus.Swap = 1'b0;
        step();
        step();
        chk("swaptick.e52.dig", 8'(bus.DigitSel), 8'(DIG_UP));
        bus.DownCount = 4'h5;
        repeat (3) step();
        chk("swaptick.e55.dig", 8'(bus.DigitSel), 8'(DIG_UP));
        step();
        chk_out("swaptick.e56", DIG_DOWN, SEG5);
        chk("swaptick.e56.match", 8'(bus.Match), 8'd1);

        // asynchronous reset between edges
        #2;
        ResetN = 1'b0;
        #1;
        chk_out("areset", DIG_NONE, SEG_BLANK);
        chk("areset.match", 8'(bus.Match), 8'd0);

        // zero digit display
        step();
        bus.UpCount   = 4'h0;
        bus.DownCount = 4'h7;
        bus.Swap      = 1'b0;
        bus.Enable    = 1'b1;
        ResetN        = 1'b1;
        e             = 0;
        step();
        chk("zero.e1.dig", 8'(bus.DigitSel), 8'(DIG_UP));
        step();
`ifdef COUNT_DISPLAY_BLANK_EN
        chk_out("zero.e2", DIG_UP, SEG_BLANK);
`else
        chk_out("zero.e2", DIG_UP, SEG0);
`endif
        repeat (4) step();
        chk_out("zero.e6", DIG_DOWN, SEG7);
        chk("zero.e6.match", 8'(bus.Match), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/count_display_mux.md
Name: count_display_mux

Overview:
- Downstream consumer of the up/down counter's `UpCountS`/`DownCountS` outputs.
- Captures both 4-bit counts and time-multiplexes them onto a 2-digit common-bus 7-segment display.
- Reports when the two captured counts are equal.
- Sits between the counter stage and the board-level display pins.

Parameters:
- WIDTH, 4, bit width of each count input (decoder covers 0-F; WIDTH fixed at 4 for the decoder).
- PRESCALE, 4, Clock cycles each digit stays selected before the scan advances (legal 1..65535).

Ports:
- Clock  input  1  system clock, rising edge.
- ResetN  input  1  asynchronous active-low reset.
- Enable  input  1  1 = capture counts this cycle; 0 = hold last captured values.
- Swap  input  1  direction flag from the counter stage; any change restarts the scan.
- UpCount  input  WIDTH  up-count value from the counter stage.
- DownCount  input  WIDTH  down-count value from the counter stage.
- Segments  output  7  active-high segments, bit order {g,f,e,d,c,b,a}.
- DigitSel  output  2  one-hot digit enable; 01 = digit 0, 10 = digit 1, 00 = none.
- Match  output  1  1 when the captured UpReg equals the captured DownReg.

Behaviour:
- Reset is asynchronous on ResetN low. It clears:
  - UpReg, DownReg, PreCnt, SwapQ to 0.
  - State to SHOW_UP.
  - Segments to 0, DigitSel to 00, Match to 0.
- Capture: on each rising edge with Enable=1, UpReg<=UpCount and DownReg<=DownCount. With Enable=0 both hold.
- SwapQ<=Swap every edge. A swap event is Swap!=SwapQ.
- Prescaler:
  - PreCnt is ceil(log2(PRESCALE)) bits, minimum 1 bit.
  - It increments every cycle.
  - At PRESCALE-1 it wraps to 0 and asserts a one-cycle `Tick`.
  - With PRESCALE=1, Tick is asserted every cycle.
- State machine, 2 states:
  - SHOW_UP -> SHOW_DOWN on Tick.
  - SHOW_DOWN -> SHOW_UP on Tick.
- Swap event has priority over Tick in the same cycle: State<=SHOW_UP and PreCnt<=0 (scan restart).
- Output stage, registered from current State/UpReg/DownReg:
  - SHOW_UP: DigitSel<=01, Segments<=decode(UpReg).
  - SHOW_DOWN: DigitSel<=10, Segments<=decode(DownReg).
- Latency:
  - Count to Segments is 2 edges: the capture edge, then the output edge.
  - State change to DigitSel is 1 edge.
- Match: registered, Match<=(UpReg==DownReg). It therefore lags capture by 1 edge.
- Hex decode values: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Boundaries:
  - Reset mid-scan: outputs go to their reset values immediately.
  - After release, the first edge gives DigitSel=01.
  - Enable toggling never disturbs the scan timing.
  - Simultaneous Enable and Tick: the new capture is displayed from the following output edge.
  - DigitSel is never 11.

Optional Feature:
- Macro: COUNT_DISPLAY_BLANK_EN.
- Defined: a digit whose selected captured value is 0 drives Segments=0000000, while DigitSel still toggles normally. Match is unaffected.
- Undefined: 0 displays as 0111111.

Decomposition:
- Package count_display_pkg contains:
  - `typedef enum logic {SHOW_UP, SHOW_DOWN} scan_state_t`.
  - SEG_W=7.
  - SEG_BLANK=7'b0.
  - DIG_UP=2'b01, DIG_DOWN=2'b10.
- One combinational sub-module, hex_to_seg (4-bit in, 7-bit out), instanced once and fed by a mux on State.

Test Plan:
- Reset/capture:
  - Stimulus: ResetN low with random inputs.
  - Required: Segments=0, DigitSel=00, Match=0.
  - Stimulus: release ResetN, then Enable=1, UpCount=3, DownCount=C, PRESCALE=4.
  - Required: by the 2nd edge, DigitSel=01 and Segments=1001111.
  - Required: 4 edges later, DigitSel=10 and Segments=0111001.
- Hold:
  - Stimulus: Enable=0, then change UpCount to 8.
  - Required: Segments still shows 3 on digit 0 for 3 full scan cycles.
  - Stimulus: Enable=1.
  - Required: 1111111 appears on the next SHOW_UP output.
- Match:
  - Stimulus: capture Up=5, Down=5.
  - Required: Match=1 one edge after capture.
  - Stimulus: capture Down=4.
  - Required: Match=0 one edge later.
- Swap restart:
  - Stimulus: toggle Swap while in SHOW_DOWN at PreCnt=2.
  - Required: next DigitSel=01, and the next Tick comes exactly 4 cycles later.
  - Stimulus: toggle Swap in the same cycle as a Tick.
  - Required: State=SHOW_UP.
- Async reset mid-scan:
  - Stimulus: drop ResetN between clock edges.
  - Required: outputs clear without waiting for an edge.
- Feature:
  - Stimulus: COUNT_DISPLAY_BLANK_EN defined, Up=0, Down=7.
  - Required: digit 0 shows 0000000 and digit 1 shows 0000111.
  - Stimulus: same inputs with the macro undefined.
  - Required: digit 0 shows 0111111.
